// File: rtl/decimal_entry_encoder.sv
// Decimal keypad entry: buffers BCD digits and converts them to binary on Enter.
// Optional backspace on code 4'hB is enabled by defining DEC_ENTRY_BACKSPACE_EN.
module decimal_entry_encoder #(
  parameter int NUM_DIGITS   = 5,
  parameter int RESULT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                DigitVal,
  input  logic                      DigitValid,
  input  logic                      Enter,
  input  logic                      Clear,
  output logic [4*NUM_DIGITS-1:0]   DigitBuf,
  output logic [2:0]                DigitCount,
  output logic                      Busy,
  output logic [RESULT_WIDTH-1:0]   EntryResult,
  output logic                      ResultValid,
  output logic                      Overflow
);

  localparam int ACC_W = RESULT_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t                    r_state;
  logic [4*NUM_DIGITS-1:0]   r_buf;
  logic [2:0]                r_count;
  logic                      r_busy;
  logic [RESULT_WIDTH-1:0]   r_result;
  logic                      r_valid;
  logic                      r_ovf;
  logic [ACC_W-1:0]          r_acc;
  logic [2:0]                r_idx;
  logic                      r_flag;

  logic [3:0]                w_nibble;
  logic [ACC_W-1:0]          w_times10;
  logic [ACC_W-1:0]          w_next;
  logic                      w_next_ovf;
  logic                      w_digit_ok;

  // The buffer is walked from its top nibble down; unused top nibbles are zero.
  assign w_nibble   = r_buf[{r_idx, 2'b00} +: 4];
  assign w_times10  = (r_acc << 3) + (r_acc << 1);
  assign w_next     = w_times10 + {{(ACC_W-4){1'b0}}, w_nibble};
  assign w_next_ovf = |w_next[ACC_W-1:RESULT_WIDTH];
  assign w_digit_ok = (DigitVal <= 4'd9) && (r_count < 3'(NUM_DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_buf    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Clear) begin
            r_buf   <= '0;
            r_count <= '0;
          end else if (Enter) begin
            r_state <= CONVERT;
            r_busy  <= 1'b1;
            r_acc   <= '0;
            r_flag  <= 1'b0;
            r_idx   <= 3'(NUM_DIGITS - 1);
          end else if (DigitValid) begin
            if (w_digit_ok) begin
              r_buf   <= {r_buf[4*NUM_DIGITS-5:0], DigitVal};
              r_count <= r_count + 3'd1;
            end
`ifdef DEC_ENTRY_BACKSPACE_EN
            else if (DigitVal == 4'hB && r_count != 3'd0) begin
              r_buf   <= {4'h0, r_buf[4*NUM_DIGITS-1:4]};
              r_count <= r_count - 3'd1;
            end
`endif
          end
        end

        CONVERT: begin
          if (Clear) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_buf   <= '0;
            r_count <= '0;
          end else begin
            // Freeze the accumulator once it has overflowed so it cannot wrap.
            if (!r_flag) begin
              r_acc <= w_next;
              if (w_next_ovf) r_flag <= 1'b1;
            end
            if (r_idx == 3'd0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx - 3'd1;
            end
          end
        end

        DONE: begin
          r_result <= r_flag ? {RESULT_WIDTH{1'b1}} : r_acc[RESULT_WIDTH-1:0];
          r_ovf    <= r_flag;
          r_valid  <= 1'b1;
          r_buf    <= '0;
          r_count  <= '0;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign DigitBuf    = r_buf;
  assign DigitCount  = r_count;
  assign Busy        = r_busy;
  assign EntryResult = r_result;
  assign ResultValid = r_valid;
  assign Overflow    = r_ovf;

endmodule
